// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program-image loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package loader_pkg;

    // Width of the byte-lane index inside a 32-bit word.
    localparam int LANE_W = 2;

    localparam logic [7:0] MAGIC_DEF   = 8'hA5;  // start-of-frame byte
    localparam logic [7:0] ACK_OK_DEF  = 8'h4B;  // 'K'
    localparam logic [7:0] ACK_ERR_DEF = 8'h45;  // 'E'

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CSUM,
        ACK,
        RUN
    } state_t;

endpackage

// File: rtl/loader_word_pack.sv
// Little-endian 4-byte packer: the first byte lands in [7:0].
// Latency: word_valid is combinational with the 4th byte's in_valid.
// Backpressure: none; accepts a byte on every in_valid, clr drops a partial word.
//
// Ports: clk/rst (sync, active-high); clr restarts at lane 0;
// in_valid/in_data byte input; word_valid/word_data completed word.
import loader_pkg::*;

module loader_word_pack (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        word_valid,
    output logic [31:0] word_data
);

    logic [LANE_W-1:0] lane_q, lane_d;
    logic [23:0]       shift_q, shift_d;

    // The three earlier bytes sit in shift_q; the 4th goes straight to the
    // top lane so the word is available in the same cycle it completes.
    assign word_valid = in_valid && !clr && (lane_q == LANE_W'(3));
    assign word_data  = {in_data, shift_q};

    always_comb begin
        lane_d  = lane_q;
        shift_d = shift_q;
        if (clr) begin
            lane_d = '0;
        end else if (in_valid) begin
            lane_d  = lane_q + LANE_W'(1);
            shift_d = {in_data, shift_q[23:8]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q  <= '0;
            shift_q <= '0;
        end else begin
            lane_q  <= lane_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/uart_mem_loader.sv
// Loads a UART-framed program image into main memory, then acks and releases the CPU.
// Latency: last data byte -> mem_write 1 cycle; mem_write -> tx_valid 1 cycle.
// Backpressure: rx has none (bytes in ACK/RUN are dropped); tx_valid/tx_data hold until tx_ready.
//
// Ports: clk, rst (sync, active-high); rx_valid/rx_data byte stream in;
// tx_valid/tx_data/tx_ready ack byte out; mem_write/mem_wmask/mem_wdata/mem_addr
// memory write port; busy = loader owns memory; cpu_run releases the CPU (sticky);
// error = last frame rejected.
// Optional: define LOADER_CHECKSUM_EN to require a trailing mod-256 sum byte.
import loader_pkg::*;

module uart_mem_loader #(
    parameter int         ADDR_W    = 14,
    parameter int         MAX_WORDS = 16384,
    parameter logic [7:0] MAGIC     = MAGIC_DEF,
    parameter logic [7:0] ACK_OK    = ACK_OK_DEF,
    parameter logic [7:0] ACK_ERR   = ACK_ERR_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic              mem_write,
    output logic [3:0]        mem_wmask,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              busy,
    output logic              cpu_run,
    output logic              error
);

    // One extra bit so the counters can hold MAX_WORDS itself.
    localparam int CNT_W = ADDR_W + 1;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  widx_q, widx_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    logic              pack_clr;
    logic              pack_in_valid;
    logic              word_valid;
    logic [31:0]       word_data;

    loader_word_pack u_pack (
        .clk        (clk),
        .rst        (rst),
        .clr        (pack_clr),
        .in_valid   (pack_in_valid),
        .in_data    (rx_data),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        widx_d        = widx_q;
        mem_write_d   = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        tx_data_d     = tx_data_q;
        error_d       = error_q;
        pack_clr      = 1'b1;
        pack_in_valid = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        sum_d         = sum_q;
`endif
        case (state_q)
            IDLE: begin
                if (rx_valid && rx_data == MAGIC) begin
                    state_d = LEN;
                    error_d = 1'b0;
                    widx_d  = '0;
`ifdef LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            LEN: begin
                // Packer lane wraps to 0 on the 4th byte, ready for DATA.
                pack_clr      = 1'b0;
                pack_in_valid = rx_valid;
                if (word_valid) begin
                    if (word_data == 32'd0) begin
                        state_d   = ACK;
                        tx_data_d = ACK_OK;
                    end else if (word_data > 32'(MAX_WORDS)) begin
                        state_d   = ACK;
                        tx_data_d = ACK_ERR;
                        error_d   = 1'b1;
                    end else begin
                        len_d   = word_data[CNT_W-1:0];
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                pack_clr = 1'b0;
                if (widx_q != len_q) begin
                    pack_in_valid = rx_valid;
`ifdef LOADER_CHECKSUM_EN
                    if (rx_valid) begin
                        sum_d = sum_q + rx_data;
                    end
`endif
                    if (word_valid) begin
                        mem_write_d = 1'b1;
                        mem_addr_d  = widx_q[ADDR_W-1:0];
                        mem_wdata_d = word_data;
                        widx_d      = widx_q + CNT_W'(1);
                    end
                end else begin
                    // All words issued; the final write is on the port this
                    // cycle, so leave DATA only now to keep busy high across it.
`ifdef LOADER_CHECKSUM_EN
                    state_d = CSUM;
`else
                    state_d   = ACK;
                    tx_data_d = ACK_OK;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: begin
                if (rx_valid) begin
                    state_d = ACK;
                    if (rx_data == sum_q) begin
                        tx_data_d = ACK_OK;
                    end else begin
                        tx_data_d = ACK_ERR;
                        error_d   = 1'b1;
                    end
                end
            end
`endif
            ACK: begin
                if (tx_ready) begin
                    state_d = (tx_data_q == ACK_OK) ? RUN : IDLE;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            widx_q      <= '0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            tx_data_q   <= '0;
            error_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            widx_q      <= widx_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            tx_data_q   <= tx_data_d;
            error_q     <= error_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    assign tx_valid  = (state_q == ACK);
    assign tx_data   = tx_data_q;
    assign mem_write = mem_write_q;
    assign mem_wmask = {4{mem_write_q}};
    assign mem_wdata = mem_wdata_q;
    assign mem_addr  = mem_addr_q;
    assign busy      = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
    assign cpu_run   = (state_q == RUN);
    assign error     = error_q;

endmodule

// File: doc/uart_mem_loader.md
Name: uart_mem_loader

Overview:
- Sits between the UART receiver byte stream and the 64 KiB SPRAM main-memory write port.
- Streams a program image into main memory word by word while holding the CPU pipeline in reset.
- When the image is complete, it returns an acknowledge byte on the UART transmit stream and releases the CPU.
- The top level muxes its memory port onto the SPRAM port whenever busy=1.

Parameters:
ADDR_W, 14, word-address width of main memory (16384 words = 64 KiB)
MAX_WORDS, 16384, largest accepted image length in words
MAGIC, 8'hA5, start-of-frame byte
ACK_OK, 8'h4B, success response ('K')
ACK_ERR, 8'h45, error response ('E')

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
rx_valid  in  1  one-cycle strobe: rx_data holds a received byte
rx_data  in  8  received byte
tx_valid  out  1  response byte available
tx_data  out  8  response byte
tx_ready  in  1  transmitter accepts byte when tx_valid&tx_ready
mem_write  out  1  one-cycle word write strobe
mem_wmask  out  4  byte enables; always 4'hF while mem_write=1, else 0
mem_wdata  out  32  word data, little-endian byte assembly
mem_addr  out  ADDR_W  word address
busy  out  1  loader owns the memory port (LEN, DATA, CSUM states)
cpu_run  out  1  releases pipeline reset; sticky until rst
error  out  1  last frame rejected; cleared on next MAGIC

Behaviour:
- Reset values: tx_valid=0, tx_data=0, mem_write=0, mem_wmask=0, mem_wdata=0, mem_addr=0, busy=0, cpu_run=0, error=0. FSM goes to IDLE; byte counter, word counter and sum are all 0.
- rst asserted mid-frame aborts the frame immediately. No further writes occur; words already written stay in memory.
- FSM states: IDLE, LEN, DATA, CSUM (feature only), ACK, RUN.
- IDLE:
  - rx byte == MAGIC -> LEN, error<=0.
  - Any other byte is ignored.
- LEN: collect 4 bytes, little-endian, into a 32-bit len.
  - On the 4th byte: len==0 -> ACK with ACK_OK.
  - len>MAX_WORDS -> ACK with ACK_ERR, error<=1.
  - Otherwise -> DATA.
- DATA:
  - Bytes are packed little-endian into a word (byte 0 -> [7:0]).
  - On the 4th byte of a word: the next cycle has mem_write=1, mem_addr=word index, mem_wdata=the word.
  - Word index increments after each write.
  - rx_valid may arrive every cycle; the write pulse overlaps with assembly of the next word without loss.
  - After the last word's write: -> CSUM if the feature is enabled, else -> ACK with ACK_OK.
- ACK:
  - tx_valid=1 with the chosen byte; held stable until tx_ready.
  - On handshake: OK -> RUN; ERR -> IDLE.
  - rx bytes received in ACK are dropped.
- RUN:
  - cpu_run=1, busy=0; all rx ignored until rst.
  - The lowest image word (address 0) is the CPU entry point (the boot code jumps there).
- The word index never exceeds MAX_WORDS-1, so there is no wrap-around.
- busy drops in the same cycle the FSM enters ACK, so the final write has completed before the CPU is released.
- Latency:
  - Last data byte to mem_write: 1 cycle.
  - mem_write to tx_valid: 1 cycle.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum (mod 256) of all DATA bytes is kept; length bytes are excluded.
  - After the last word, CSUM waits for one byte.
  - Byte equal to the sum -> ACK_OK. Mismatch -> ACK_ERR, error<=1; memory contents are left as written.
- Undefined:
  - No CSUM state and no sum register; DATA goes straight to ACK_OK.

Decomposition:
- Package loader_pkg holds:
  - state enum {IDLE, LEN, DATA, CSUM, ACK, RUN};
  - MAGIC, ACK_OK and ACK_ERR defaults;
  - the byte-lane index width (2 bits).
- One sub-module, loader_word_pack: 4-byte shift/pack with a lane counter.
  - Emits word_valid plus the word; clearable by the FSM.
  - Shared by the LEN and DATA states.

Test Plan:
- Bytes 00 A5 02 00 00 00 11 22 33 44 55 66 77 88 back-to-back -> writes addr0=32'h44332211, addr1=32'h88776655, then tx 8'h4B; after tx_ready, cpu_run=1, busy=0.
- A5 00 00 00 00 -> no mem_write, tx 8'h4B, cpu_run=1.
- A5 01 40 00 00 (len=16385) -> no writes, error=1, tx 8'h45, back in IDLE; then a valid 1-word frame -> error=0, ACK_OK.
- tx_ready held low 20 cycles in ACK -> tx_valid and tx_data stable; extra rx bytes dropped; RUN entered only on the handshake.
- rst pulsed after 6 of 8 data bytes -> all outputs at reset values next cycle; only addr0 was written.
- With LOADER_CHECKSUM_EN: 1-word frame 01 02 03 04, csum 8'h0A -> ACK_OK; csum 8'h0B -> ACK_ERR, error=1, cpu_run=0.
